logic_clock_domain_crossing_generic_write: RTL and testbench



---
 rtl/logic_clock_domain_crossing_generic_write.sv | 113 +++++++++++
 tb/tb_logic_clock_domain_crossing_generic_write.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/logic_clock_domain_crossing_generic_write.sv
// ---------------------------------------------------------------------------
// logic_clock_domain_crossing_generic_write
//
// Write side of the generic dual-clock FIFO. This block lives in the producer
// (rx) clock domain. It accepts an AXI4-Stream-style input and drives the
// write port of the dual-port storage. It owns the binary write pointer and
// flags full against the read pointer once that pointer has been
// synchronised into this domain. Usable capacity is 2^ADDRESS_WIDTH - 1
// entries.
//
// Ports
//   rx_aclk              producer clock
//   rx_areset            asynchronous reset, active-high
//   rx_tvalid / rx_tdata producer stream input
//   rx_tready            block can accept data this cycle
//   write_enable         storage write strobe (rx_tvalid && rx_tready)
//   write_pointer        storage write address, binary, wraps
//   write_data           storage write data (rx_tdata, unregistered)
//   read_pointer_synced  read pointer already synchronised into rx_aclk
// ---------------------------------------------------------------------------
module logic_clock_domain_crossing_generic_write #(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     rx_aclk,
    input  logic                     rx_areset,
    input  logic                     rx_tvalid,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    output logic                     rx_tready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_pointer_synced
);

    localparam int                       ALMOST_FULL = 2;
    localparam logic [ADDRESS_WIDTH-1:0] MAX         = '1;
    localparam logic [ADDRESS_WIDTH-1:0] AF_LEVEL    = MAX - ADDRESS_WIDTH'(ALMOST_FULL);

    // The two-bit exact compare below only disambiguates full when the
    // pipelined margin covers at least the full-minus-two region.
    if (ADDRESS_WIDTH < 3) begin : g_drc
        $error("ADDRESS_WIDTH must be at least 3");
    end

    typedef enum logic {
        FSM_RESET,
        FSM_ACTIVE
    } fsm_t;

    fsm_t                     state;
    logic                     active;
    logic [ADDRESS_WIDTH-1:0] difference;
    logic                     almost_full;
    logic                     full;
    logic [1:0]               wp_lo_next;

    // One idle cycle after reset, then accept for good.
    always_ff @(posedge rx_aclk or posedge rx_areset) begin
        if (rx_areset) begin
            state  <= FSM_RESET;
            active <= 1'b0;
        end else begin
            case (state)
                FSM_RESET: begin
                    state  <= FSM_ACTIVE;
                    active <= 1'b1;
                end
                default: begin
                    state  <= FSM_ACTIVE;
                    active <= 1'b1;
                end
            endcase
        end
    end

    // almost_full is two cycles stale relative to write_pointer. At most two
    // writes can happen in that window, so a margin of ALMOST_FULL entries
    // keeps full from being missed. The exact low-bit compare then selects
    // the real full point, which also lets a read-pointer advance release
    // rx_tready in the same cycle.
    assign wp_lo_next   = write_pointer[1:0] + 2'd1;
    assign full         = almost_full && (wp_lo_next == read_pointer_synced[1:0]);
    assign rx_tready    = active && !full;
    assign write_enable = rx_tvalid && rx_tready;
    assign write_data   = rx_tdata;

    always_ff @(posedge rx_aclk or posedge rx_areset) begin
        if (rx_areset) begin
            write_pointer <= '0;
            difference    <= '0;
            almost_full   <= 1'b0;
        end else begin
            if (write_enable) begin
                write_pointer <= write_pointer + 1'b1;
            end
            difference  <= write_pointer - read_pointer_synced;
            almost_full <= (difference >= AF_LEVEL);
        end
    end

`ifndef LOGIC_STD_OVL_DISABLED
    // Fill level may never jump between empty and full in one step.
    a_no_overflow: assert property (@(posedge rx_aclk) disable iff (rx_areset)
        !(($past(difference) == MAX) && (difference == '0)))
        else $error("difference overflow MAX->0");

    a_no_underflow: assert property (@(posedge rx_aclk) disable iff (rx_areset)
        !(($past(difference) == '0) && (difference == MAX)))
        else $error("difference underflow 0->MAX");
`endif

endmodule

// File: tb/tb_logic_clock_domain_crossing_generic_write.sv
module tb_logic_clock_domain_crossing_generic_write;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          rx_aclk = 1'b0;
    logic          rx_areset;
    logic          rx_tvalid;
    logic [DW-1:0] rx_tdata;
    logic          rx_tready;
    logic          write_enable;
    logic [AW-1:0] write_pointer;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_pointer_synced;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr     = 0;

    logic_clock_domain_crossing_generic_write #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .rx_aclk             (rx_aclk),
        .rx_areset           (rx_areset),
        .rx_tvalid           (rx_tvalid),
        .rx_tdata            (rx_tdata),
        .rx_tready           (rx_tready),
        .write_enable        (write_enable),
        .write_pointer       (write_pointer),
        .write_data          (write_data),
        .read_pointer_synced (read_pointer_synced)
    );

    always #5 rx_aclk = ~rx_aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled well away from the edge.
    task automatic tick();
        @(posedge rx_aclk);
        #1;
    endtask

    // Trailing read pointer: n_wr - 3, clamped at zero, modulo depth.
    function automatic logic [AW-1:0] trail_rp(input int n);
        return (n >= 3) ? AW'(n - 3) : '0;
    endfunction

    initial begin
        rx_areset           = 1'b1;
        rx_tvalid           = 1'b1;
        rx_tdata            = '0;
        read_pointer_synced = '0;

        // Reset state with valid held high
        tick();
        tick();
        chk("rst_tready", 32'(rx_tready), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_wp", 32'(write_pointer), 32'd0);

        // Release: first cycle not ready, second cycle writes address 0
        rx_areset = 1'b0;
        #1;
        chk("rel_tready_c1", 32'(rx_tready), 32'd0);
        chk("rel_we_c1", 32'(write_enable), 32'd0);
        tick();
        chk("rel_tready_c2", 32'(rx_tready), 32'd1);

        // Fill with read pointer frozen at 0: 7 writes at addresses 0..6
        for (int i = 0; i < 7; i++) begin
            rx_tdata = DW'(i + 1);
            #1;
            chk("fill_we", 32'(write_enable), 32'd1);
            chk("fill_wp", 32'(write_pointer), 32'(i));
            chk("fill_wd", 32'(write_data), 32'(i + 1));
            tick();
        end
        chk("full_tready", 32'(rx_tready), 32'd0);
        chk("full_we", 32'(write_enable), 32'd0);
        chk("full_wp", 32'(write_pointer), 32'd7);
        tick();
        chk("stall_wp", 32'(write_pointer), 32'd7);
        chk("stall_tready", 32'(rx_tready), 32'd0);

        // Read pointer advances: ready same cycle, write at 7, then full again
        read_pointer_synced = 3'd1;
        #1;
        chk("rel_full_tready", 32'(rx_tready), 32'd1);
        chk("rel_full_we", 32'(write_enable), 32'd1);
        chk("rel_full_wp", 32'(write_pointer), 32'd7);
        tick();
        chk("refull_wp", 32'(write_pointer), 32'd0);
        chk("refull_tready", 32'(rx_tready), 32'd0);

        // Clean restart
        rx_tvalid           = 1'b0;
        rx_areset           = 1'b1;
        read_pointer_synced = '0;
        tick();
        rx_areset = 1'b0;
        tick();

        // 40 writes, read pointer trailing by 3: wraps 5 times, never stalls
        n_wr = 0;
        for (int i = 0; i < 40; i++) begin
            read_pointer_synced = trail_rp(n_wr);
            rx_tvalid           = 1'b1;
            rx_tdata            = DW'($urandom_range(0, 15));
            #1;
            chk("wrap_we", 32'(write_enable), 32'd1);
            chk("wrap_wp", 32'(write_pointer), 32'(n_wr % 8));
            chk("wrap_wd", 32'(write_data), 32'(rx_tdata));
            tick();
            n_wr++;
        end
        chk("wrap_end_wp", 32'(write_pointer), 32'd0);

        // Valid toggling with data 0xA, 0xB, ...
        for (int k = 0; k < 6; k++) begin
            read_pointer_synced = trail_rp(n_wr);
            rx_tvalid           = (k % 2 == 0);
            rx_tdata            = DW'(4'hA + k);
            #1;
            chk("tog_we", 32'(write_enable), 32'(k % 2 == 0));
            chk("tog_wp", 32'(write_pointer), 32'(n_wr % 8));
            chk("tog_wd", 32'(write_data), 32'(4'hA + k));
            tick();
            if (k % 2 == 0) n_wr++;
        end

        // Reset in the middle of a stream
        rx_tvalid           = 1'b0;
        rx_areset           = 1'b1;
        read_pointer_synced = '0;
        tick();
        rx_areset = 1'b0;
        tick();
        rx_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_tdata = DW'(i);
            tick();
        end
        chk("mid_wp_before", 32'(write_pointer), 32'd4);
        rx_areset = 1'b1;
        #1;
        chk("mid_rst_tready", 32'(rx_tready), 32'd0);
        chk("mid_rst_wp", 32'(write_pointer), 32'd0);
        chk("mid_rst_we", 32'(write_enable), 32'd0);
        tick();
        rx_areset = 1'b0;
        #1;
        chk("mid_rel_tready", 32'(rx_tready), 32'd0);
        tick();
        chk("mid_restart_we", 32'(write_enable), 32'd1);
        chk("mid_restart_wp", 32'(write_pointer), 32'd0);
        tick();
        chk("mid_restart_wp1", 32'(write_pointer), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
